// File: rtl/icache_direct.sv
// Direct-mapped instruction cache: one outstanding block fill, read-only.
// Optional flush port and drop-on-flush behaviour under `ICACHE_FLUSH_EN.
module icache_direct #(
    parameter int BLK_BYTES = 32,
    parameter int NUM_LINES = 16,
    parameter int ADDR_W    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,
`ifdef ICACHE_FLUSH_EN
    input  logic                   flush,
`endif
    input  logic                   if_req,
    input  logic [ADDR_W-1:0]      if_pc,
    output logic                   if_ready,
    output logic                   inst_valid,
    output logic [31:0]            inst,
    output logic                   mem_en,
    output logic [ADDR_W-1:0]      mem_pc,
    input  logic                   mem_done,
    input  logic [BLK_BYTES*8-1:0] mem_data
);

    localparam int OFF = $clog2(BLK_BYTES);
    localparam int IDX = $clog2(NUM_LINES);
    localparam int TW  = ADDR_W - OFF - IDX;
    localparam int WPL = BLK_BYTES / 4;
    localparam int WW  = (WPL > 1) ? $clog2(WPL) : 1;
    localparam int LW  = BLK_BYTES * 8;

    typedef enum logic {
        IDLE,
        MISS
    } state_e;

    state_e            state_q, state_d;
    logic              mem_en_q, mem_en_d;
    logic [ADDR_W-1:0] mem_pc_q, mem_pc_d;
    logic              inst_valid_q, inst_valid_d;
    logic [31:0]       inst_q, inst_d;
    logic [WW-1:0]     wsel_q, wsel_d;
    logic              drop_q, drop_d;

    logic [NUM_LINES-1:0] valid_q;
    logic [TW-1:0]        tag_q  [NUM_LINES];
    logic [LW-1:0]        data_q [NUM_LINES];

    logic [IDX-1:0] req_idx;
    logic [TW-1:0]  req_tag;
    logic [WW-1:0]  req_wsel;
    logic           req_hit;
    logic [IDX-1:0] fill_idx;
    logic [TW-1:0]  fill_tag;
    logic           fill_we;
    logic           flush_now;
    logic           unused_lo;

    function automatic logic [31:0] word_of(
        input logic [LW-1:0] line,
        input logic [WW-1:0] w
    );
        return line[int'(w)*32 +: 32];
    endfunction

`ifdef ICACHE_FLUSH_EN
    assign flush_now = flush;
`else
    assign flush_now = 1'b0;
`endif

    assign req_idx  = if_pc[OFF+IDX-1:OFF];
    assign req_tag  = if_pc[ADDR_W-1:OFF+IDX];
    assign req_hit  = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign fill_idx = mem_pc_q[OFF+IDX-1:OFF];
    assign fill_tag = mem_pc_q[ADDR_W-1:OFF+IDX];

    generate
        if (WPL > 1) begin : g_wsel
            assign req_wsel = if_pc[OFF-1:2];
        end else begin : g_wsel1
            assign req_wsel = '0;
        end
    endgenerate

    // Byte-offset bits never take part in lookup or fill addressing.
    assign unused_lo = ^{if_pc[1:0], mem_pc_q[OFF-1:0]};

    always_comb begin
        state_d      = state_q;
        mem_en_d     = mem_en_q;
        mem_pc_d     = mem_pc_q;
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        wsel_d       = wsel_q;
        drop_d       = drop_q;
        fill_we      = 1'b0;
        if (rdy) begin
            inst_valid_d = 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (if_req && !flush_now) begin
                        if (req_hit) begin
                            inst_valid_d = 1'b1;
                            inst_d       = word_of(data_q[req_idx], req_wsel);
                        end else begin
                            state_d  = MISS;
                            mem_en_d = 1'b1;
                            mem_pc_d = {if_pc[ADDR_W-1:OFF], {OFF{1'b0}}};
                            wsel_d   = req_wsel;
                        end
                    end
                end
                MISS: begin
                    if (flush_now) begin
                        drop_d = 1'b1;
                    end
                    if (mem_done) begin
                        state_d  = IDLE;
                        mem_en_d = 1'b0;
                        drop_d   = 1'b0;
                        // A flush seen at any point of the fill discards it.
                        if (!(drop_q || flush_now)) begin
                            fill_we      = 1'b1;
                            inst_valid_d = 1'b1;
                            inst_d       = word_of(mem_data, wsel_q);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            mem_en_q     <= 1'b0;
            mem_pc_q     <= '0;
            inst_valid_q <= 1'b0;
            inst_q       <= '0;
            wsel_q       <= '0;
            drop_q       <= 1'b0;
            valid_q      <= '0;
        end else begin
            state_q      <= state_d;
            mem_en_q     <= mem_en_d;
            mem_pc_q     <= mem_pc_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            wsel_q       <= wsel_d;
            drop_q       <= drop_d;
            if (rdy && flush_now) begin
                valid_q <= '0;
            end else if (fill_we) begin
                valid_q[fill_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= mem_data;
        end
    end

    assign if_ready   = (state_q == IDLE) && !flush_now;
    assign inst_valid = inst_valid_q;
    assign inst       = inst_q;
    assign mem_en     = mem_en_q;
    assign mem_pc     = mem_pc_q;

endmodule

// File: tb/tb_icache_direct.sv
// Self-checking bench for icache_direct against a line-level cache model.
// Build with +define+ICACHE_FLUSH_EN to also exercise the flush port.
module tb_icache_direct;

    localparam int BLK   = 32;
    localparam int LINES = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           rdy;
    logic           if_req;
    logic [31:0]    if_pc;
    logic           if_ready;
    logic           inst_valid;
    logic [31:0]    inst;
    logic           mem_en;
    logic [31:0]    mem_pc;
    logic           mem_done;
    logic [BLK*8-1:0] mem_data;
`ifdef ICACHE_FLUSH_EN
    logic           flush;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    bit          mvalid [LINES];
    int unsigned mtag   [LINES];

    icache_direct #(
        .BLK_BYTES(BLK),
        .NUM_LINES(LINES),
        .ADDR_W(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rdy(rdy),
`ifdef ICACHE_FLUSH_EN
        .flush(flush),
`endif
        .if_req(if_req),
        .if_pc(if_pc),
        .if_ready(if_ready),
        .inst_valid(inst_valid),
        .inst(inst),
        .mem_en(mem_en),
        .mem_pc(mem_pc),
        .mem_done(mem_done),
        .mem_data(mem_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_1004) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    function automatic logic [BLK*8-1:0] blk(input logic [31:0] base);
        logic [BLK*8-1:0] b;
        for (int k = 0; k < BLK / 4; k++) b[k*32 +: 32] = mem_word(base + 32'(4 * k));
        return b;
    endfunction

    function automatic bit model_hit(input logic [31:0] pc);
        int unsigned i;
        i = (pc / BLK) % LINES;
        return mvalid[i] && mtag[i] == pc / (BLK * LINES);
    endfunction

    function automatic void model_fill(input logic [31:0] pc);
        int unsigned i;
        i = (pc / BLK) % LINES;
        mvalid[i] = 1'b1;
        mtag[i]   = pc / (BLK * LINES);
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < LINES; i++) mvalid[i] = 1'b0;
    endfunction

    task automatic do_fetch(input logic [31:0] pc, input int lat);
        bit          exp_hit;
        logic [31:0] base;
        logic [31:0] exp_w;
        exp_hit = model_hit(pc);
        base    = pc & ~32'(BLK - 1);
        exp_w   = mem_word(pc & ~32'h3);
        @(negedge clk);
        n_tests++;
        if (if_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL fetch_ready pc=%h: if_ready=%b want 1", pc, if_ready);
        end
        if_req = 1'b1;
        if_pc  = pc;
        @(posedge clk); #1;
        if_req = 1'b0;
        if_pc  = $urandom;
        if (exp_hit) begin
            n_tests++;
            if (inst_valid !== 1'b1 || inst !== exp_w || mem_en !== 1'b0) begin
                n_fail++;
                $display("FAIL hit pc=%h: valid=%b inst=%h mem_en=%b want 1 %h 0",
                         pc, inst_valid, inst, mem_en, exp_w);
            end
        end else begin
            n_tests++;
            if (inst_valid !== 1'b0 || mem_en !== 1'b1 || mem_pc !== base || if_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL miss_req pc=%h: valid=%b mem_en=%b mem_pc=%h rdy=%b want 0 1 %h 0",
                         pc, inst_valid, mem_en, mem_pc, if_ready, base);
            end
            for (int c = 0; c < lat; c++) begin
                @(posedge clk); #1;
                n_tests++;
                if (mem_en !== 1'b1 || mem_pc !== base || inst_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL miss_hold pc=%h: mem_en=%b mem_pc=%h valid=%b want 1 %h 0",
                             pc, mem_en, mem_pc, inst_valid, base);
                end
            end
            @(negedge clk);
            mem_done = 1'b1;
            mem_data = blk(base);
            @(posedge clk); #1;
            mem_done = 1'b0;
            n_tests++;
            if (inst_valid !== 1'b1 || inst !== exp_w || mem_en !== 1'b0 || if_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL fill_resp pc=%h: valid=%b inst=%h mem_en=%b rdy=%b want 1 %h 0 1",
                         pc, inst_valid, inst, mem_en, if_ready, exp_w);
            end
            model_fill(pc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1; if_req = 1'b0; if_pc = '0;
        mem_done = 1'b0; mem_data = '0;
`ifdef ICACHE_FLUSH_EN
        flush = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (if_ready !== 1'b1 || inst_valid !== 1'b0 || inst !== 32'h0 ||
            mem_en !== 1'b0 || mem_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL reset: rdy=%b valid=%b inst=%h mem_en=%b mem_pc=%h want 1 0 0 0 0",
                     if_ready, inst_valid, inst, mem_en, mem_pc);
        end
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_cold_miss();
        do_fetch(32'h0000_1004, 2);
    endtask

    task automatic test_hit_after_fill();
        do_fetch(32'h0000_101C, 0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] pcs [3];
        pcs[0] = 32'h1000; pcs[1] = 32'h1004; pcs[2] = 32'h1008;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if_req = 1'b1;
            if_pc  = pcs[i];
            @(posedge clk); #1;
            n_tests++;
            if (inst_valid !== 1'b1 || inst !== mem_word(pcs[i]) || mem_en !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_%0d: valid=%b inst=%h mem_en=%b want 1 %h 0",
                         i, inst_valid, inst, mem_en, mem_word(pcs[i]));
            end
        end
        @(negedge clk);
        if_req = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (inst_valid !== 1'b0 || inst !== mem_word(32'h1008)) begin
            n_fail++;
            $display("FAIL b2b_hold: valid=%b inst=%h want 0 %h",
                     inst_valid, inst, mem_word(32'h1008));
        end
    endtask

    task automatic test_idle_done();
        @(negedge clk);
        mem_done = 1'b1;
        mem_data = {8{32'hDEAD_BEEF}};
        @(posedge clk); #1;
        mem_done = 1'b0;
        n_tests++;
        if (inst_valid !== 1'b0 || mem_en !== 1'b0 || if_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_done: valid=%b mem_en=%b rdy=%b want 0 0 1",
                     inst_valid, mem_en, if_ready);
        end
        do_fetch(32'h0000_1010, 0);
    endtask

    task automatic test_rdy_stall();
        logic [31:0] w;
        w = mem_word(32'h1008);
        @(negedge clk);
        if_req = 1'b1;
        if_pc  = 32'h1008;
        @(posedge clk); #1;
        @(negedge clk);
        rdy    = 1'b0;
        if_pc  = 32'h5000;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            n_tests++;
            if (inst_valid !== 1'b1 || inst !== w || mem_en !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hit_%0d: valid=%b inst=%h mem_en=%b want 1 %h 0",
                         c, inst_valid, inst, mem_en, w);
            end
        end
        @(negedge clk);
        rdy    = 1'b1;
        if_req = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (inst_valid !== 1'b0 || inst !== w) begin
            n_fail++;
            $display("FAIL stall_hit_end: valid=%b inst=%h want 0 %h", inst_valid, inst, w);
        end
        @(negedge clk);
        if_req = 1'b1;
        if_pc  = 32'h2048;
        @(posedge clk); #1;
        if_req = 1'b0;
        @(negedge clk);
        rdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            n_tests++;
            if (mem_en !== 1'b1 || mem_pc !== 32'h2040 || if_ready !== 1'b0 || inst_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_miss_%0d: mem_en=%b mem_pc=%h rdy=%b valid=%b want 1 2040 0 0",
                         c, mem_en, mem_pc, if_ready, inst_valid);
            end
        end
        @(negedge clk);
        rdy      = 1'b1;
        mem_done = 1'b1;
        mem_data = blk(32'h2040);
        @(posedge clk); #1;
        mem_done = 1'b0;
        n_tests++;
        if (inst_valid !== 1'b1 || inst !== mem_word(32'h2048) || mem_en !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_fill: valid=%b inst=%h mem_en=%b want 1 %h 0",
                     inst_valid, inst, mem_en, mem_word(32'h2048));
        end
        model_fill(32'h2048);
        @(posedge clk); #1;
        n_tests++;
        if (inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_pulse: valid=%b want 0", inst_valid);
        end
    endtask

    task automatic test_conflict();
        do_fetch(32'h0000_1200, 1);
        do_fetch(32'h0000_1000, 1);
    endtask

    task automatic test_reset_mid_miss();
        do_fetch(32'h0000_3000, 0);
        @(negedge clk);
        if_req = 1'b1;
        if_pc  = 32'h3100;
        @(posedge clk); #1;
        if_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (mem_en !== 1'b0 || if_ready !== 1'b1 || inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_miss: mem_en=%b rdy=%b valid=%b want 0 1 0",
                     mem_en, if_ready, inst_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        do_fetch(32'h0000_3000, 1);
    endtask

`ifdef ICACHE_FLUSH_EN
    task automatic test_flush();
        @(negedge clk);
        if_req = 1'b1;
        if_pc  = 32'h4004;
        @(posedge clk); #1;
        if_req = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        model_clear();
        @(negedge clk);
        flush = 1'b0;
        n_tests++;
        if (mem_en !== 1'b1 || mem_pc !== 32'h4000) begin
            n_fail++;
            $display("FAIL flush_miss_hold: mem_en=%b mem_pc=%h want 1 4000", mem_en, mem_pc);
        end
        mem_done = 1'b1;
        mem_data = blk(32'h4000);
        @(posedge clk); #1;
        mem_done = 1'b0;
        n_tests++;
        if (inst_valid !== 1'b0 || mem_en !== 1'b0 || if_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_drop: valid=%b mem_en=%b rdy=%b want 0 0 1",
                     inst_valid, mem_en, if_ready);
        end
        do_fetch(32'h0000_4004, 1);
        @(negedge clk);
        flush  = 1'b1;
        if_req = 1'b1;
        if_pc  = 32'h4004;
        #1;
        n_tests++;
        if (if_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle_ready: rdy=%b want 0", if_ready);
        end
        @(posedge clk); #1;
        flush  = 1'b0;
        if_req = 1'b0;
        model_clear();
        n_tests++;
        if (inst_valid !== 1'b0 || mem_en !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle: valid=%b mem_en=%b want 0 0", inst_valid, mem_en);
        end
        do_fetch(32'h0000_4004, 0);
    endtask
`endif

    task automatic test_random();
        logic [31:0] pc;
        int          gap;
        for (int n = 0; n < 200; n++) begin
            pc = 32'h0001_0000 | ($urandom_range(0, 3) << 9) | ($urandom_range(0, 3) << 5) |
                 ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            do_fetch(pc, $urandom_range(0, 3));
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(posedge clk); #1;
                n_tests++;
                if (inst_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rand_pulse n=%0d: valid=%b want 0", n, inst_valid);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit_after_fill();
        test_back_to_back();
        test_idle_done();
        test_rdy_stall();
        test_conflict();
        test_reset_mid_miss();
`ifdef ICACHE_FLUSH_EN
        test_flush();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
